// File: rtl/router_pkg.sv
// Shared types and sizing for the router FSM slice.
// Optional feature: ROUTER_FSM_ADDR_CHECK_EN adds the DROP_PKT state for header address 2'b11.
package router_pkg;

  localparam int unsigned AddrWidth = 2;
  localparam int unsigned NumFifos  = 3;

  typedef enum logic [3:0] {
    StDecodeAddress    = 4'd0,
    StLoadFirstData    = 4'd1,
    StLoadData         = 4'd2,
    StFifoFullState    = 4'd3,
    StLoadAfterFull    = 4'd4,
    StLoadParity       = 4'd5,
    StCheckParityError = 4'd6,
    StWaitTillEmpty    = 4'd7
`ifdef ROUTER_FSM_ADDR_CHECK_EN
    ,
    StDropPkt          = 4'd8
`endif
  } state_e;

endpackage

// File: rtl/router_fsm_addr_mux.sv
// Selects the empty flag and soft reset of the FIFO addressed by the latched header address.
module router_fsm_addr_mux
  import router_pkg::*;
(
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [NumFifos-1:0]  fifo_empty_i,
  input  logic [NumFifos-1:0]  soft_reset_i,
  output logic                 fifo_empty_o,
  output logic                 soft_reset_o
);

  // Address 2'b11 has no FIFO: report not-empty and no soft reset.
  always_comb begin
    fifo_empty_o = 1'b0;
    soft_reset_o = 1'b0;
    case (addr_i)
      2'd0: begin
        fifo_empty_o = fifo_empty_i[0];
        soft_reset_o = soft_reset_i[0];
      end
      2'd1: begin
        fifo_empty_o = fifo_empty_i[1];
        soft_reset_o = soft_reset_i[1];
      end
      2'd2: begin
        fifo_empty_o = fifo_empty_i[2];
        soft_reset_o = soft_reset_i[2];
      end
      default: begin
        fifo_empty_o = 1'b0;
        soft_reset_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/router_fsm.sv
// Router control FSM: sequences header decode, payload load, FIFO-full stalls and parity.
// Optional feature: ROUTER_FSM_ADDR_CHECK_EN drops packets addressed to 2'b11.
module router_fsm
  import router_pkg::*;
(
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 pkt_valid_i,
  input  logic [AddrWidth-1:0] data_in_i,
  input  logic                 parity_done_i,
  input  logic                 low_pkt_valid_i,
  input  logic                 fifo_full_i,
  input  logic                 fifo_empty_0_i,
  input  logic                 fifo_empty_1_i,
  input  logic                 fifo_empty_2_i,
  input  logic                 soft_reset_0_i,
  input  logic                 soft_reset_1_i,
  input  logic                 soft_reset_2_i,
  output logic                 busy_o,
  output logic                 detect_add_o,
  output logic                 lfd_state_o,
  output logic                 ld_state_o,
  output logic                 laf_state_o,
  output logic                 full_state_o,
  output logic                 write_enb_reg_o,
  output logic                 rst_int_reg_o
);

  state_e               state_q, state_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [NumFifos-1:0]  fifo_empty_vec;
  logic [NumFifos-1:0]  soft_reset_vec;
  logic                 fifo_empty_addr;
  logic                 soft_reset_addr;

  assign fifo_empty_vec = {fifo_empty_2_i, fifo_empty_1_i, fifo_empty_0_i};
  assign soft_reset_vec = {soft_reset_2_i, soft_reset_1_i, soft_reset_0_i};

  router_fsm_addr_mux u_addr_mux (
    .addr_i       (addr_q),
    .fifo_empty_i (fifo_empty_vec),
    .soft_reset_i (soft_reset_vec),
    .fifo_empty_o (fifo_empty_addr),
    .soft_reset_o (soft_reset_addr)
  );

  // State and captured header address; reset abandons any packet in flight.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= StDecodeAddress;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  // Next-state logic; a soft reset of the selected FIFO overrides everything.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    unique case (state_q)
      StDecodeAddress: begin
        if (pkt_valid_i) begin
          addr_d = data_in_i;
          // The header byte itself picks the FIFO, addr_q is not yet valid here.
          case (data_in_i)
            2'd0:    state_d = fifo_empty_vec[0] ? StLoadFirstData : StWaitTillEmpty;
            2'd1:    state_d = fifo_empty_vec[1] ? StLoadFirstData : StWaitTillEmpty;
            2'd2:    state_d = fifo_empty_vec[2] ? StLoadFirstData : StWaitTillEmpty;
`ifdef ROUTER_FSM_ADDR_CHECK_EN
            default: state_d = StDropPkt;
`else
            default: state_d = StDecodeAddress;
`endif
          endcase
        end
      end
      StLoadFirstData: state_d = StLoadData;
      StLoadData: begin
        if (fifo_full_i) begin
          state_d = StFifoFullState;
        end else if (!pkt_valid_i) begin
          state_d = StLoadParity;
        end
      end
      StFifoFullState: begin
        if (!fifo_full_i) begin
          state_d = StLoadAfterFull;
        end
      end
      StLoadAfterFull: begin
        if (parity_done_i) begin
          state_d = StDecodeAddress;
        end else if (low_pkt_valid_i) begin
          state_d = StLoadParity;
        end else begin
          state_d = StLoadData;
        end
      end
      StLoadParity: state_d = StCheckParityError;
      StCheckParityError: state_d = fifo_full_i ? StFifoFullState : StDecodeAddress;
      StWaitTillEmpty: begin
        if (fifo_empty_addr) begin
          state_d = StLoadFirstData;
        end
      end
`ifdef ROUTER_FSM_ADDR_CHECK_EN
      StDropPkt: begin
        if (!pkt_valid_i) begin
          state_d = StDecodeAddress;
        end
      end
`endif
      default: state_d = StDecodeAddress;
    endcase

    if (state_q != StDecodeAddress && soft_reset_addr) begin
      state_d = StDecodeAddress;
    end
  end

  // Moore outputs decoded straight from the state register.
  always_comb begin
    busy_o          = 1'b0;
    detect_add_o    = 1'b0;
    lfd_state_o     = 1'b0;
    ld_state_o      = 1'b0;
    laf_state_o     = 1'b0;
    full_state_o    = 1'b0;
    write_enb_reg_o = 1'b0;
    rst_int_reg_o   = 1'b0;
    unique case (state_q)
      StDecodeAddress: detect_add_o = 1'b1;
      StLoadFirstData: begin
        lfd_state_o = 1'b1;
        busy_o      = 1'b1;
      end
      StLoadData: begin
        ld_state_o      = 1'b1;
        write_enb_reg_o = 1'b1;
      end
      StFifoFullState: begin
        full_state_o = 1'b1;
        busy_o       = 1'b1;
      end
      StLoadAfterFull: begin
        laf_state_o     = 1'b1;
        write_enb_reg_o = 1'b1;
        busy_o          = 1'b1;
      end
      StLoadParity: begin
        write_enb_reg_o = 1'b1;
        busy_o          = 1'b1;
      end
      StCheckParityError: begin
        rst_int_reg_o = 1'b1;
        busy_o        = 1'b1;
      end
      StWaitTillEmpty: busy_o = 1'b1;
      default: begin
        busy_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_router_fsm.sv
// Scoreboard bench for router_fsm: stimulus pushes expected output vectors, a monitor checks them.
module tb_router_fsm;

  // Output vector order: busy, detect_add, lfd, ld, laf, full, write_enb, rst_int.
  localparam logic [7:0] EDa   = 8'b0100_0000;
  localparam logic [7:0] ELfd  = 8'b1010_0000;
  localparam logic [7:0] ELd   = 8'b0001_0010;
  localparam logic [7:0] EFull = 8'b1000_0100;
  localparam logic [7:0] ELaf  = 8'b1000_1010;
  localparam logic [7:0] ELp   = 8'b1000_0010;
  localparam logic [7:0] ECpe  = 8'b1000_0001;
  localparam logic [7:0] EWte  = 8'b1000_0000;
  localparam logic [7:0] EDrop = 8'b0000_0000;

  logic       clock = 1'b0;
  logic       resetn;
  logic       pkt_valid, parity_done, low_pkt_valid, fifo_full;
  logic [1:0] data_in;
  logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;
  logic       busy, detect_add, lfd_state, ld_state, laf_state, full_state;
  logic       write_enb_reg, rst_int_reg;
  logic [7:0] act;

  typedef struct {
    logic [7:0] exp;
    string      name;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  router_fsm dut (
    .clock           (clock),
    .resetn          (resetn),
    .pkt_valid_i     (pkt_valid),
    .data_in_i       (data_in),
    .parity_done_i   (parity_done),
    .low_pkt_valid_i (low_pkt_valid),
    .fifo_full_i     (fifo_full),
    .fifo_empty_0_i  (fifo_empty_0),
    .fifo_empty_1_i  (fifo_empty_1),
    .fifo_empty_2_i  (fifo_empty_2),
    .soft_reset_0_i  (soft_reset_0),
    .soft_reset_1_i  (soft_reset_1),
    .soft_reset_2_i  (soft_reset_2),
    .busy_o          (busy),
    .detect_add_o    (detect_add),
    .lfd_state_o     (lfd_state),
    .ld_state_o      (ld_state),
    .laf_state_o     (laf_state),
    .full_state_o    (full_state),
    .write_enb_reg_o (write_enb_reg),
    .rst_int_reg_o   (rst_int_reg)
  );

  always #5 clock = ~clock;

  assign act = {busy, detect_add, lfd_state, ld_state, laf_state, full_state,
                write_enb_reg, rst_int_reg};

  // Monitor: one expected vector per cycle, compared mid-cycle.
  always @(negedge clock) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      n_tests++;
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got %b expected %b (t=%0t)", e.name, act, e.exp, $time);
      end
    end
  end

  // Clock edge with current inputs, then queue what the outputs must be afterwards.
  task automatic cyc(input logic [7:0] exp, input string name);
    exp_t e;
    @(posedge clock);
    #1;
    e.exp  = exp;
    e.name = name;
    sb_q.push_back(e);
  endtask

  task automatic idle_inputs();
    pkt_valid     = 1'b0;
    data_in       = 2'd0;
    parity_done   = 1'b0;
    low_pkt_valid = 1'b0;
    fifo_full     = 1'b0;
    fifo_empty_0  = 1'b1;
    fifo_empty_1  = 1'b1;
    fifo_empty_2  = 1'b1;
    soft_reset_0  = 1'b0;
    soft_reset_1  = 1'b0;
    soft_reset_2  = 1'b0;
  endtask

  initial begin
    exp_t e;
    resetn = 1'b0;
    idle_inputs();
    cyc(EDa, "reset_state");
    resetn = 1'b1;
    cyc(EDa, "idle_after_reset");

    // Normal packet to FIFO 1 with 12 payload cycles.
    pkt_valid = 1'b1;
    data_in   = 2'd1;
    cyc(ELfd, "norm_lfd");
    for (int i = 0; i < 12; i++) begin
      data_in = 2'(i);
      cyc(ELd, "norm_ld");
    end
    pkt_valid = 1'b0;
    cyc(ELp, "norm_lp");
    cyc(ECpe, "norm_cpe");
    cyc(EDa, "norm_back_da");
    cyc(EDa, "norm_idle");

    // FIFO full for three cycles during payload, then parity path through full again.
    pkt_valid = 1'b1;
    data_in   = 2'd0;
    cyc(ELfd, "full_lfd");
    cyc(ELd, "full_ld");
    fifo_full = 1'b1;
    cyc(EFull, "full_1");
    cyc(EFull, "full_2");
    cyc(EFull, "full_3");
    fifo_full = 1'b0;
    cyc(ELaf, "full_laf");
    cyc(ELd, "full_back_ld");
    pkt_valid = 1'b0;
    cyc(ELp, "full_lp");
    fifo_full = 1'b1;
    cyc(ECpe, "full_cpe");
    cyc(EFull, "cpe_to_full");
    fifo_full = 1'b0;
    cyc(ELaf, "cpe_laf");
    parity_done = 1'b1;
    cyc(EDa, "laf_parity_done");
    parity_done = 1'b0;

    // Busy FIFO 2: wait five cycles; other FIFOs' flags must not matter.
    pkt_valid    = 1'b1;
    data_in      = 2'd2;
    fifo_empty_2 = 1'b0;
    cyc(EWte, "wait_1");
    data_in = 2'd0;
    for (int i = 2; i <= 5; i++) begin
      cyc(EWte, "wait_n");
    end
    fifo_empty_2 = 1'b1;
    cyc(ELfd, "wait_lfd");
    cyc(ELd, "wait_ld");
    soft_reset_2 = 1'b1;
    cyc(EDa, "soft_rst_2");
    soft_reset_2 = 1'b0;
    pkt_valid    = 1'b0;
    cyc(EDa, "wait_idle");

    // Soft reset: only the selected FIFO's soft reset counts.
    pkt_valid = 1'b1;
    data_in   = 2'd0;
    cyc(ELfd, "srst_lfd");
    cyc(ELd, "srst_ld");
    soft_reset_1 = 1'b1;
    cyc(ELd, "srst_other_1");
    cyc(ELd, "srst_other_2");
    soft_reset_1 = 1'b0;
    soft_reset_0 = 1'b1;
    cyc(EDa, "srst_sel");
    pkt_valid = 1'b0;
    cyc(EDa, "srst_in_da");
    soft_reset_0 = 1'b0;

    // Header address 3 held for four cycles.
    pkt_valid = 1'b1;
    data_in   = 2'd3;
`ifdef ROUTER_FSM_ADDR_CHECK_EN
    for (int i = 0; i < 4; i++) cyc(EDrop, "drop");
`else
    for (int i = 0; i < 4; i++) cyc(EDa, "addr3_stay");
`endif
    pkt_valid = 1'b0;
    cyc(EDa, "addr3_after");

    // Load-after-full with low_pkt_valid goes straight to parity.
    pkt_valid = 1'b1;
    data_in   = 2'd1;
    cyc(ELfd, "low_lfd");
    cyc(ELd, "low_ld");
    fifo_full = 1'b1;
    cyc(EFull, "low_full");
    fifo_full     = 1'b0;
    low_pkt_valid = 1'b1;
    cyc(ELaf, "low_laf");
    cyc(ELp, "low_lp");
    low_pkt_valid = 1'b0;
    pkt_valid     = 1'b0;
    cyc(ECpe, "low_cpe");
    cyc(EDa, "low_da");

    // Asynchronous reset mid-payload, checked before the next clock edge.
    pkt_valid = 1'b1;
    data_in   = 2'd0;
    cyc(ELfd, "arst_lfd");
    cyc(ELd, "arst_ld");
    @(posedge clock);
    #1;
    resetn = 1'b0;
    e.exp  = EDa;
    e.name = "async_reset";
    sb_q.push_back(e);
    cyc(EDa, "reset_held");
    resetn    = 1'b1;
    pkt_valid = 1'b0;
    cyc(EDa, "post_reset_idle");

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 4 && sb_q.size() > 0; i++) @(negedge clock);
    #1;
    if (sb_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/router_fsm.md
ROUTER_FSM -- requirements
Module: router_fsm

Interface
REQ-001 SHALL have port clock, input, 1, the single rising-edge clock.
REQ-002 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-003 SHALL have inputs pkt_valid 1 (byte-valid from source), data_in 2 (address bits [1:0] of header), parity_done 1, low_pkt_valid 1 (from register block).
REQ-004 SHALL have inputs fifo_full 1 (selected FIFO full), fifo_empty_0/1/2 1 each, soft_reset_0/1/2 1 each (from sync block).
REQ-005 SHALL have outputs busy, detect_add, lfd_state, ld_state, laf_state, full_state, write_enb_reg, rst_int_reg, 1 bit each.

Function
REQ-006 SHALL be a Moore FSM, states: DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR, WAIT_TILL_EMPTY (plus DROP_PKT, see REQ-021).
REQ-007 SHALL latch data_in into a 2-bit addr register in DECODE_ADDRESS when pkt_valid=1; addr holds until the next DECODE_ADDRESS capture.
REQ-008 DECODE_ADDRESS: pkt_valid & data_in=k (k in 0..2) & fifo_empty_k -> LOAD_FIRST_DATA; pkt_valid & data_in=k & !fifo_empty_k -> WAIT_TILL_EMPTY; else stay.
REQ-009 LOAD_FIRST_DATA -> LOAD_DATA unconditionally.
REQ-010 LOAD_DATA: fifo_full -> FIFO_FULL_STATE; else !pkt_valid -> LOAD_PARITY; else stay (fifo_full has priority).
REQ-011 FIFO_FULL_STATE: stay while fifo_full; else -> LOAD_AFTER_FULL.
REQ-012 LOAD_AFTER_FULL: parity_done -> DECODE_ADDRESS; else low_pkt_valid -> LOAD_PARITY; else -> LOAD_DATA.
REQ-013 LOAD_PARITY -> CHECK_PARITY_ERROR; CHECK_PARITY_ERROR: fifo_full -> FIFO_FULL_STATE, else -> DECODE_ADDRESS.
REQ-014 WAIT_TILL_EMPTY: fifo_empty_addr -> LOAD_FIRST_DATA; else stay.
REQ-015 In any state except DECODE_ADDRESS, soft_reset_addr=1 SHALL force DECODE_ADDRESS on the next edge, overriding all other transitions; soft_reset of non-selected FIFOs SHALL be ignored.
REQ-016 Outputs decoded from state only: detect_add=DECODE_ADDRESS; lfd_state=LOAD_FIRST_DATA; ld_state=LOAD_DATA; full_state=FIFO_FULL_STATE; laf_state=LOAD_AFTER_FULL; rst_int_reg=CHECK_PARITY_ERROR.
REQ-017 write_enb_reg SHALL be 1 in LOAD_DATA, LOAD_PARITY, LOAD_AFTER_FULL only.
REQ-018 busy SHALL be 1 in every state except DECODE_ADDRESS, LOAD_DATA, DROP_PKT.
REQ-019 Output change latency SHALL be zero cycles after the state register update; no output registered separately.

Reset
REQ-020 resetn=0 SHALL asynchronously force state=DECODE_ADDRESS, addr=0; hence detect_add=1 and all other outputs 0; reset mid-packet SHALL abandon the packet.

Configuration
REQ-021 With ROUTER_FSM_ADDR_CHECK_EN defined: DECODE_ADDRESS with pkt_valid & data_in=2'b11 -> DROP_PKT; DROP_PKT stays while pkt_valid, then -> DECODE_ADDRESS, all outputs 0.
REQ-022 Without ROUTER_FSM_ADDR_CHECK_EN: DROP_PKT SHALL not exist; data_in=2'b11 SHALL leave FSM in DECODE_ADDRESS.

Structure
REQ-023 State encoding (localparam/enum, 4-bit), address width and FIFO count (3) SHALL live in shared package router_pkg.
REQ-024 One sub-module router_fsm_addr_mux SHALL select fifo_empty_addr and soft_reset_addr from the 3-bit vectors by addr; everything else in router_fsm.

Verification
REQ-025 Reset: resetn=0 mid-LOAD_DATA -> state DECODE_ADDRESS immediately, detect_add=1, busy=0.
REQ-026 Normal packet: header addr=1, fifo_empty_1=1, 12 payload cycles, pkt_valid drops -> lfd_state 1 cycle, ld_state 12 cycles, LOAD_PARITY, CHECK_PARITY_ERROR (rst_int_reg=1), DECODE_ADDRESS.
REQ-027 Full: fifo_full=1 during LOAD_DATA for 3 cycles -> full_state=1, busy=1, write_enb_reg=0 for 3 cycles, then laf_state=1 one cycle, return to LOAD_DATA (low_pkt_valid=0).
REQ-028 Busy FIFO: addr=2, fifo_empty_2=0 for 5 cycles -> WAIT_TILL_EMPTY, busy=1 five cycles, then LOAD_FIRST_DATA.
REQ-029 Soft reset: addr=0 in LOAD_DATA, soft_reset_1=1 -> no effect; soft_reset_0=1 -> DECODE_ADDRESS next edge.
REQ-030 Macro: data_in=2'b11, pkt_valid 4 cycles -> with ROUTER_FSM_ADDR_CHECK_EN: DROP_PKT 4 cycles, busy=0, write_enb_reg=0, then DECODE_ADDRESS; without: stays in DECODE_ADDRESS throughout.
